// File: rtl/seg_pkg.sv
// Shared constants for the bist result display: active-low 7-segment
// encodings {g,f,e,d,c,b,a}, the blank pattern and the digit count.
package seg_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bist_seg_display.sv
// Stability-filtered 4-digit multiplexed hex display of the bist result bus;
// test mode splits test count / CRC8 with the decimal point.
module bist_seg_display
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_ZEROS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       value,
    input  logic              test_mode,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int SCW = $clog2(STABLE_CYCLES) + 1;
    localparam int RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SCW-1:0] SC_MAX = SCW'(STABLE_CYCLES - 1);
    localparam logic [RCW-1:0] RC_MAX = RCW'(REFRESH_DIV - 1);

    logic [15:0]       prev_value;
    logic [15:0]       disp_reg;
    logic              mode_reg;
    logic [SCW-1:0]    stable_cnt;
    logic [RCW-1:0]    refresh_cnt;
    logic [1:0]        digit_idx;

    logic              steady;
    logic [3:0]        nibble;
    logic [6:0]        seg_raw;
    logic [DIGITS-1:0] lead_zero;
    logic              blank;

    assign steady = (value == prev_value);

    // Capture only on a cycle that is itself unchanged, so a held value is
    // latched STABLE_CYCLES+1 edges after its last change and then tracked.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_value <= '0;
            stable_cnt <= '0;
            disp_reg   <= '0;
            mode_reg   <= 1'b0;
        end else begin
            prev_value <= value;
            if (!steady) begin
                stable_cnt <= '0;
            end else if (stable_cnt < SC_MAX) begin
                stable_cnt <= stable_cnt + SCW'(1);
            end else begin
                disp_reg <= value;
                mode_reg <= test_mode;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == RC_MAX) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + RCW'(1);
        end
    end

    assign nibble = disp_reg[4*digit_idx +: 4];

    hex_to_seg u_hex (
        .nibble (nibble),
        .seg    (seg_raw)
    );

    // A digit is a leading zero when it and every higher nibble are zero;
    // digit 0 always shows so a zero result still reads "0".
    always_comb begin
        lead_zero    = '0;
        lead_zero[3] = (disp_reg[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (disp_reg[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (disp_reg[7:4] == 4'h0);
    end

    assign blank = (BLANK_ZEROS != 0) && !mode_reg && lead_zero[digit_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(DIGITS'(1) << digit_idx);
            seg <= blank ? SEG_BLANK : seg_raw;
            dp  <= ~(mode_reg && (digit_idx == 2'd2));
        end
    end

endmodule
